debug_snapshot_unit: RTL

DEBUG_SNAPSHOT_UNIT -- requirements
Module: debug_snapshot_unit

---
 rtl/debug_snap_pkg.sv | 28 ++
 rtl/debug_snap_buffer.sv | 24 ++
 rtl/debug_snapshot_unit.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/debug_snap_pkg.sv
// Shared definitions for the debug snapshot unit: FSM state encoding,
// register word offsets and CTRL/STATUS bit positions.
package debug_snap_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARM       = 3'd1,
        ST_WAIT_TRIG = 3'd2,
        ST_CAPTURE   = 3'd3,
        ST_DONE      = 3'd4
    } snap_state_e;

    localparam logic [9:0] WORD_CTRL     = 10'd0;
    localparam logic [9:0] WORD_STATUS   = 10'd1;
    localparam logic [9:0] WORD_SAMPLES  = 10'd2;
    localparam logic [9:0] WORD_CH_SEL   = 10'd3;
    localparam int unsigned WORD_BUF_BASE = 256;

    localparam int CTRL_START  = 0;
    localparam int CTRL_ABORT  = 1;
    localparam int CTRL_CONT   = 2;
    localparam int CTRL_IRQ_EN = 3;

    localparam int STAT_DONE      = 8;
    localparam int STAT_OVF       = 9;
    localparam int STAT_COUNT_LSB = 16;

endpackage

// File: rtl/debug_snap_buffer.sv
// Capture storage: one synchronous write port, one asynchronous read port.
// Contents are intentionally not reset; the reader masks by capture count.
module debug_snap_buffer #(
    parameter int DEPTH      = 64,
    parameter int DATA_WIDTH = 32,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [AW-1:0]         waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]         raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) r_mem[waddr_i] <= wdata_i;
    end

    assign rdata_o = r_mem[raddr_i];

endmodule

// File: rtl/debug_snapshot_unit.sv
// Register-mapped snapshot capture: arm, wait for trigger, record one selected
// channel per cycle into a buffer (one-shot or continuous), readable over the bus.
module debug_snapshot_unit
    import debug_snap_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 64,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [7:0]                 reglk_ctrl_i,
    input  logic                       reg_valid_i,
    input  logic                       reg_write_i,
    input  logic [ADDR_WIDTH-1:0]      reg_addr_i,
    input  logic [DATA_WIDTH-1:0]      reg_wdata_i,
    output logic [DATA_WIDTH-1:0]      reg_rdata_o,
    output logic                       reg_ready_o,
    output logic                       reg_error_o,
    input  logic [N_CH*DATA_WIDTH-1:0] snap_data_i,
    input  logic                       trig_i,
    output logic                       irq_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(DEPTH) + 1;
    localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;

    snap_state_e     r_state;
    logic            r_cont;
    logic            r_irq_en;
    logic [SW-1:0]   r_samples;
    logic [CW-1:0]   r_ch_sel;
    logic [SW-1:0]   r_lat_samples;
    logic [CW-1:0]   r_lat_ch;
    logic [SW-1:0]   r_count;
    logic [AW-1:0]   r_wr_ptr;
    logic            r_done;
    logic            r_ovf;
    logic            r_irq;

    // ---------------- address decode ----------------
    logic [9:0]  w_widx;
    logic [10:0] w_widx_x;
    logic [10:0] w_boff;
    logic        w_hit_ctrl, w_hit_status, w_hit_samp, w_hit_chsel, w_hit_buf;
    logic        w_unmapped;
    logic        w_wr;
    logic        w_ctrl_wr, w_samp_wr, w_chsel_wr, w_status_wr;

    assign w_widx       = reg_addr_i[11:2];
    assign w_widx_x     = {1'b0, w_widx};
    assign w_boff       = w_widx_x - 11'(WORD_BUF_BASE);
    assign w_hit_ctrl   = (w_widx == WORD_CTRL);
    assign w_hit_status = (w_widx == WORD_STATUS);
    assign w_hit_samp   = (w_widx == WORD_SAMPLES);
    assign w_hit_chsel  = (w_widx == WORD_CH_SEL);
    assign w_hit_buf    = (w_widx_x >= 11'(WORD_BUF_BASE)) &&
                          (w_widx_x <  11'(WORD_BUF_BASE + DEPTH));
    assign w_unmapped   = !(w_hit_ctrl || w_hit_status || w_hit_samp ||
                            w_hit_chsel || w_hit_buf);

    assign w_wr        = reg_valid_i && reg_write_i;
    assign w_ctrl_wr   = w_wr && w_hit_ctrl && !reglk_ctrl_i[0];
    assign w_samp_wr   = w_wr && w_hit_samp && !reglk_ctrl_i[1];
    assign w_chsel_wr  = w_wr && w_hit_chsel && !reglk_ctrl_i[1];
    assign w_status_wr = w_wr && w_hit_status;

    assign reg_ready_o = 1'b1;
    assign reg_error_o = reg_valid_i && (w_unmapped ||
                         (reg_write_i && ((w_hit_ctrl && reglk_ctrl_i[0]) ||
                                          ((w_hit_samp || w_hit_chsel) && reglk_ctrl_i[1]) ||
                                          w_hit_buf)));

    // ---------------- capture datapath ----------------
    logic                               w_start, w_abort;
    logic                               w_start_ok;
    logic                               w_we;
    logic [SW-1:0]                      w_count_inc;
    logic                               w_count_full;
    logic                               w_shot_end;
    logic [N_CH-1:0][DATA_WIDTH-1:0]    w_ch;
    logic [DATA_WIDTH-1:0]              w_buf_rdata;

    assign w_start      = w_ctrl_wr && reg_wdata_i[CTRL_START];
    assign w_abort      = w_ctrl_wr && reg_wdata_i[CTRL_ABORT];
    // ABORT outranks START; START is only honoured from a quiescent state
    assign w_start_ok   = w_start && !w_abort &&
                          (r_state == ST_IDLE || r_state == ST_DONE);
    assign w_we         = (r_state == ST_CAPTURE) && !w_abort;
    assign w_count_inc  = r_count + SW'(1);
    assign w_count_full = (r_count == SW'(DEPTH));
    assign w_shot_end   = w_we && !r_cont && (w_count_inc == r_lat_samples);
    assign w_ch         = snap_data_i;

    debug_snap_buffer #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .AW         (AW)
    ) u_buf (
        .clk_i   (clk_i),
        .we_i    (w_we),
        .waddr_i (r_wr_ptr),
        .wdata_i (w_ch[r_lat_ch]),
        .raddr_i (w_boff[AW-1:0]),
        .rdata_o (w_buf_rdata)
    );

    // ---------------- sticky status next-state ----------------
    logic w_done_set, w_done_nxt, w_ovf_set, w_ovf_nxt, w_irq_en_nxt;

    assign w_done_set = w_shot_end || ((r_state == ST_CAPTURE) && w_abort);
    assign w_ovf_set  = w_we && r_cont && w_count_full;

    // hardware set wins over a coincident W1C
    always_comb begin
        w_done_nxt = r_done;
        w_ovf_nxt  = r_ovf;
        if (w_start_ok) begin
            w_done_nxt = 1'b0;
            w_ovf_nxt  = 1'b0;
        end
        if (w_status_wr && reg_wdata_i[STAT_DONE]) w_done_nxt = 1'b0;
        if (w_status_wr && reg_wdata_i[STAT_OVF])  w_ovf_nxt  = 1'b0;
        if (w_done_set) w_done_nxt = 1'b1;
        if (w_ovf_set)  w_ovf_nxt  = 1'b1;
    end

    assign w_irq_en_nxt = w_ctrl_wr ? reg_wdata_i[CTRL_IRQ_EN] : r_irq_en;

    // ---------------- control FSM and registers ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state       <= ST_IDLE;
            r_cont        <= 1'b0;
            r_irq_en      <= 1'b0;
            r_samples     <= '0;
            r_ch_sel      <= '0;
            r_lat_samples <= '0;
            r_lat_ch      <= '0;
            r_count       <= '0;
            r_wr_ptr      <= '0;
            r_done        <= 1'b0;
            r_ovf         <= 1'b0;
            r_irq         <= 1'b0;
        end else begin
            if (w_ctrl_wr) begin
                r_cont   <= reg_wdata_i[CTRL_CONT];
                r_irq_en <= reg_wdata_i[CTRL_IRQ_EN];
            end
            if (w_samp_wr)  r_samples <= reg_wdata_i[SW-1:0];
            if (w_chsel_wr) r_ch_sel  <= reg_wdata_i[CW-1:0];
            r_done <= w_done_nxt;
            r_ovf  <= w_ovf_nxt;
            r_irq  <= w_done_nxt && w_irq_en_nxt;

            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_start_ok) begin
                        r_state  <= ST_ARM;
                        r_count  <= '0;
                        r_wr_ptr <= '0;
                        if (r_samples == '0)
                            r_lat_samples <= SW'(1);
                        else if (r_samples > SW'(DEPTH))
                            r_lat_samples <= SW'(DEPTH);
                        else
                            r_lat_samples <= r_samples;
                        r_lat_ch <= (int'(r_ch_sel) >= N_CH) ? '0 : r_ch_sel;
                    end
                end
                ST_ARM: r_state <= w_abort ? ST_IDLE : ST_WAIT_TRIG;
                ST_WAIT_TRIG: begin
                    if (w_abort)     r_state <= ST_IDLE;
                    else if (trig_i) r_state <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    if (w_abort) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_wr_ptr <= r_wr_ptr + AW'(1);
                        if (!w_count_full) r_count <= w_count_inc;
                        if (w_shot_end)    r_state <= ST_DONE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign irq_o = r_irq;

    // ---------------- read mux ----------------
    always_comb begin
        reg_rdata_o = '0;
        if (w_hit_ctrl) begin
            reg_rdata_o[CTRL_CONT]   = r_cont;
            reg_rdata_o[CTRL_IRQ_EN] = r_irq_en;
        end else if (w_hit_status) begin
            reg_rdata_o[2:0]                         = r_state;
            reg_rdata_o[STAT_DONE]                   = r_done;
            reg_rdata_o[STAT_OVF]                    = r_ovf;
            reg_rdata_o[STAT_COUNT_LSB +: 16]        = 16'(r_count);
        end else if (w_hit_samp) begin
            reg_rdata_o[SW-1:0] = r_samples;
        end else if (w_hit_chsel) begin
            reg_rdata_o[CW-1:0] = r_ch_sel;
        end else if (w_hit_buf && (w_boff < 11'(r_count))) begin
            reg_rdata_o = w_buf_rdata;
        end
    end

endmodule
